mem_stage: RTL

Memory-access stage of the 5-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the writeback stage. It resolves the branch decision from Branch/Zero and performs loads and stores through a request/acknowledge data-memory port. While an access is in flight it stalls the upstream pipeline. It also registers the MEM/WB values consumed by writeback.

---
 rtl/mem_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MIPS memory-access stage: branch resolve, req/ack data-memory port with timeout, MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        Mem2Reg_in,
  input  logic        Zero_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] Reg2_in,
  input  logic [4:0]  WriteReg_in,
  output logic        PCSrc_out,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic        RegWrite_out,
  output logic        Mem2Reg_out,
  output logic [31:0] MemData_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  WriteReg_out,
  output logic        bus_err_out,
  output logic        align_err_out,
  output logic        dbg_state_o
);

  // Handshake: dmem_req stays high from the IDLE request cycle until the cycle
  // dmem_ack is seen (or the timeout fires); addr/we/wdata follow the held inputs.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        regwrite_q, regwrite_d;
  logic        mem2reg_q, mem2reg_d;
  logic [31:0] memdata_q, memdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  wr_q, wr_d;
  logic        bus_err_q, bus_err_d;
  logic        align_err_q, align_err_d;

  logic mem_op;
  logic misalign;
  logic req;
  logic stall;
  logic load_instr;

  assign mem_op = valid_in & (MemRead_in | MemWrite_in);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (ALU_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req         = 1'b0;
    stall       = 1'b0;
    load_instr  = 1'b0;
    bus_err_d   = 1'b0;
    align_err_d = 1'b0;
    memdata_d   = memdata_q;
    case (state_q)
      S_IDLE: begin
        if (misalign) begin
          align_err_d = 1'b1;
        end else if (mem_op) begin
          req     = 1'b1;
          stall   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end else begin
          load_instr = 1'b1;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          load_instr = 1'b1;
          if (!MemWrite_in) memdata_d = dmem_rdata;
          state_d = S_IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          // Give up: release the pipeline and drop the instruction.
          bus_err_d = 1'b1;
          cnt_d     = 8'd0;
          state_d   = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Anything not loading an instruction loads a bubble; data fields hold.
  always_comb begin
    valid_d    = 1'b0;
    regwrite_d = 1'b0;
    mem2reg_d  = mem2reg_q;
    alu_d      = alu_q;
    wr_d       = wr_q;
    if (load_instr) begin
      valid_d    = valid_in;
      regwrite_d = RegWrite_in & valid_in;
      mem2reg_d  = Mem2Reg_in;
      alu_d      = ALU_in;
      wr_d       = WriteReg_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      mem2reg_q   <= 1'b0;
      memdata_q   <= 32'd0;
      alu_q       <= 32'd0;
      wr_q        <= 5'd0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      mem2reg_q   <= mem2reg_d;
      memdata_q   <= memdata_d;
      alu_q       <= alu_d;
      wr_q        <= wr_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end

  // Gating with rst lets an abandoned request drop without waiting for a clock.
  assign dmem_req   = rst & req;
  assign dmem_we    = rst & req & MemWrite_in;
  assign stall_out  = rst & stall;
  assign dmem_addr  = ALU_in;
  assign dmem_wdata = Reg2_in;
  assign PCSrc_out  = valid_in & Branch_in & Zero_in;

  assign valid_out     = valid_q;
  assign RegWrite_out  = regwrite_q;
  assign Mem2Reg_out   = mem2reg_q;
  assign MemData_out   = memdata_q;
  assign ALU_out       = alu_q;
  assign WriteReg_out  = wr_q;
  assign bus_err_out   = bus_err_q;
  assign align_err_out = align_err_q;
  assign dbg_state_o   = state_q;

endmodule
